// File: rtl/diff_commit_queue_pkg.sv
// rtl/diff_commit_queue_pkg.sv - shared difftest record types and constants
package diff_commit_queue_pkg;

  localparam int DIFF_IDX_W = 8;

  // One committed instruction as seen by the difftest consumer.
  typedef struct packed {
    logic [DIFF_IDX_W-1:0] idx;
    logic [63:0]           pc;
    logic [31:0]           instr;
    logic                  skip;
    logic                  wen;
    logic [7:0]            wdest;
    logic [63:0]           wdata;
  } commit_rec_t;

endpackage

// File: rtl/commit_ring.sv
// rtl/commit_ring.sv - dual-write single-read circular record buffer
module commit_ring
  import diff_commit_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr0_en,
  input  commit_rec_t              wr0_rec,
  input  logic                     wr1_en,
  input  commit_rec_t              wr1_rec,
  input  logic                     rd_en,
  output commit_rec_t              rd_rec,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH)-1:0] tail
);

  localparam int PW = $clog2(DEPTH);

  commit_rec_t   mem [DEPTH];
  logic [PW-1:0] tail_p1;
  logic [PW:0]   n_push;
  logic [PW:0]   n_pop;

  // wr1 is only ever asserted together with wr0, so it always lands right after tail.
  assign tail_p1 = tail + PW'(1);
  assign n_push  = (PW+1)'(wr0_en) + (PW+1)'(wr1_en);
  assign n_pop   = (PW+1)'(rd_en);
  assign rd_rec  = mem[head];

  // Payload storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (wr0_en) mem[tail]    <= wr0_rec;
    if (wr1_en) mem[tail_p1] <= wr1_rec;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (rd_en) head <= head + PW'(1);
      tail  <= tail + n_push[PW-1:0];
      count <= count + n_push - n_pop;
    end
  end

endmodule

// File: rtl/diff_commit_queue.sv
// rtl/diff_commit_queue.sv - dual-commit difftest record queue with order/hang checks
module diff_commit_queue
  import diff_commit_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in0_valid,
  input  logic [DIFF_IDX_W-1:0] in0_index,
  input  logic [63:0]           in0_pc,
  input  logic [31:0]           in0_instr,
  input  logic                  in0_skip,
  input  logic                  in0_wen,
  input  logic [7:0]            in0_wdest,
  input  logic [63:0]           in0_wdata,
  input  logic                  in1_valid,
  input  logic [DIFF_IDX_W-1:0] in1_index,
  input  logic [63:0]           in1_pc,
  input  logic [31:0]           in1_instr,
  input  logic                  in1_skip,
  input  logic                  in1_wen,
  input  logic [7:0]            in1_wdest,
  input  logic [63:0]           in1_wdata,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIFF_IDX_W-1:0] out_index,
  output logic [63:0]           out_pc,
  output logic [31:0]           out_instr,
  output logic                  out_skip,
  output logic                  out_wen,
  output logic [7:0]            out_wdest,
  output logic [63:0]           out_wdata,
  output logic [63:0]           commit_cnt,
  output logic                  order_err,
  output logic [DIFF_IDX_W-1:0] err_expect,
  output logic                  overflow,
  output logic                  hang
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  commit_rec_t           rec0, rec1, rec_a, head_rec;
  logic [CW-1:0]         ring_count;
  logic [PW-1:0]         ring_head, ring_tail;
  logic                  any_valid, dual, illegal, accept;
  logic                  push_a, push_b, pop;
  logic                  mis_a, mis_b;
  logic [1:0]            n_acc;
  logic [DIFF_IDX_W-1:0] exp_idx, exp_b;
  logic [IW-1:0]         idle_q, idle_d;

  assign rec0 = '{idx: in0_index, pc: in0_pc, instr: in0_instr, skip: in0_skip,
                  wen: in0_wen, wdest: in0_wdest, wdata: in0_wdata};
  assign rec1 = '{idx: in1_index, pc: in1_pc, instr: in1_instr, skip: in1_skip,
                  wen: in1_wen, wdest: in1_wdest, wdata: in1_wdata};

  // Ready depends on the registered count only: one free slot is never enough.
  assign in_ready  = (ring_count <= CW'(DEPTH - 2));
  assign out_valid = (ring_count != '0);
  assign pop       = out_valid && out_ready;

  assign any_valid = in0_valid || in1_valid;
  assign dual      = in0_valid && in1_valid;
  assign illegal   = in1_valid && !in0_valid;
  assign accept    = any_valid && in_ready;
  assign push_a    = accept;
  assign push_b    = accept && dual;
  // A lone port-1 record is still queued, taking the first slot.
  assign rec_a     = in0_valid ? rec0 : rec1;
  assign n_acc     = 2'(push_a) + 2'(push_b);

  assign exp_b = exp_idx + DIFF_IDX_W'(1);
  assign mis_a = push_a && (rec_a.idx != exp_idx);
  assign mis_b = push_b && (rec1.idx != exp_b);

  commit_ring #(.DEPTH(DEPTH)) u_ring (
    .clock   (clock),
    .reset   (reset),
    .wr0_en  (push_a),
    .wr0_rec (rec_a),
    .wr1_en  (push_b),
    .wr1_rec (rec1),
    .rd_en   (pop),
    .rd_rec  (head_rec),
    .count   (ring_count),
    .head    (ring_head),
    .tail    (ring_tail)
  );

  assign out_index = head_rec.idx;
  assign out_pc    = head_rec.pc;
  assign out_instr = head_rec.instr;
  assign out_skip  = head_rec.skip;
  assign out_wen   = head_rec.wen;
  assign out_wdest = head_rec.wdest;
  assign out_wdata = head_rec.wdata;

  // Idle cycles since the last accepted record, saturating at TIMEOUT.
  always_comb begin
    idle_d = idle_q;
    if (n_acc != 2'd0)             idle_d = '0;
    else if (idle_q != IW'(TIMEOUT)) idle_d = idle_q + IW'(1);
  end

  // Sequence tracking, commit counting and the sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_idx    <= '0;
      commit_cnt <= '0;
      order_err  <= 1'b0;
      err_expect <= '0;
      overflow   <= 1'b0;
      hang       <= 1'b0;
      idle_q     <= '0;
    end else begin
      exp_idx    <= exp_idx + DIFF_IDX_W'(n_acc);
      commit_cnt <= commit_cnt + 64'(n_acc);
      idle_q     <= idle_d;
      // Only the first error is captured; the older record's expectation wins.
      if (!order_err && (mis_a || mis_b || illegal)) begin
        order_err  <= 1'b1;
        err_expect <= (mis_b && !mis_a) ? exp_b : exp_idx;
      end
      if (any_valid && !in_ready) overflow <= 1'b1;
      if (idle_d == IW'(TIMEOUT)) hang <= 1'b1;
    end
  end

  // Occupancy must always equal the pointer distance modulo DEPTH.
  always_comb begin
    assert (PW'(ring_tail - ring_head) == ring_count[PW-1:0]);
  end

endmodule

// File: tb/tb_diff_commit_queue.sv
// tb/tb_diff_commit_queue.sv - self-checking bench for diff_commit_queue
module tb_diff_commit_queue;
  import diff_commit_queue_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic        clock, reset;
  logic        in0_valid, in1_valid, out_ready;
  logic [7:0]  in0_index, in1_index, in0_wdest, in1_wdest;
  logic [63:0] in0_pc, in1_pc, in0_wdata, in1_wdata;
  logic [31:0] in0_instr, in1_instr;
  logic        in0_skip, in1_skip, in0_wen, in1_wen;
  logic        in_ready, out_valid, out_skip, out_wen;
  logic [7:0]  out_index, out_wdest, err_expect;
  logic [63:0] out_pc, out_wdata, commit_cnt;
  logic [31:0] out_instr;
  logic        order_err, overflow, hang;

  int checks = 0;
  int errors = 0;

  // Reference model state
  commit_rec_t mq[$];
  logic [7:0]  m_expect, m_err_expect;
  longint      m_cnt;
  bit          m_order_err, m_overflow, m_hang;
  int          m_idle;

  diff_commit_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .in0_valid(in0_valid), .in0_index(in0_index), .in0_pc(in0_pc), .in0_instr(in0_instr),
    .in0_skip(in0_skip), .in0_wen(in0_wen), .in0_wdest(in0_wdest), .in0_wdata(in0_wdata),
    .in1_valid(in1_valid), .in1_index(in1_index), .in1_pc(in1_pc), .in1_instr(in1_instr),
    .in1_skip(in1_skip), .in1_wen(in1_wen), .in1_wdest(in1_wdest), .in1_wdata(in1_wdata),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_pc(out_pc), .out_instr(out_instr), .out_skip(out_skip),
    .out_wen(out_wen), .out_wdest(out_wdest), .out_wdata(out_wdata),
    .commit_cnt(commit_cnt), .order_err(order_err), .err_expect(err_expect),
    .overflow(overflow), .hang(hang)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_clear();
    mq.delete();
    m_expect = 8'd0; m_err_expect = 8'd0; m_cnt = 0;
    m_order_err = 0; m_overflow = 0; m_hang = 0; m_idle = 0;
  endtask

  task automatic drive(input bit v0, input logic [7:0] i0, input bit v1, input logic [7:0] i1);
    in0_valid = v0; in0_index = i0; in0_pc = {$urandom, $urandom}; in0_instr = $urandom;
    in0_skip = 1'($urandom_range(0, 1)); in0_wen = 1'($urandom_range(0, 1));
    in0_wdest = 8'($urandom); in0_wdata = {$urandom, $urandom};
    in1_valid = v1; in1_index = i1; in1_pc = {$urandom, $urandom}; in1_instr = $urandom;
    in1_skip = 1'($urandom_range(0, 1)); in1_wen = 1'($urandom_range(0, 1));
    in1_wdest = 8'($urandom); in1_wdata = {$urandom, $urandom};
  endtask

  // Advance one clock, updating the model from the queue semantics.
  task automatic tick();
    commit_rec_t acc[$];
    bit          rdy;
    logic [7:0]  e;
    rdy = (mq.size() <= DEPTH - 2);
    if ((in0_valid || in1_valid) && !rdy) m_overflow = 1;
    if (rdy) begin
      if (in0_valid) acc.push_back('{idx: in0_index, pc: in0_pc, instr: in0_instr, skip: in0_skip,
                                     wen: in0_wen, wdest: in0_wdest, wdata: in0_wdata});
      if (in1_valid) acc.push_back('{idx: in1_index, pc: in1_pc, instr: in1_instr, skip: in1_skip,
                                     wen: in1_wen, wdest: in1_wdest, wdata: in1_wdata});
    end
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    foreach (acc[k]) begin
      e = m_expect + 8'(k);
      if (acc[k].idx != e && !m_order_err) begin m_order_err = 1; m_err_expect = e; end
      mq.push_back(acc[k]);
    end
    if (in1_valid && !in0_valid && !m_order_err) begin m_order_err = 1; m_err_expect = m_expect; end
    m_expect = m_expect + 8'(acc.size());
    m_cnt    = m_cnt + acc.size();
    if (acc.size() != 0) m_idle = 0;
    else if (m_idle < TIMEOUT) m_idle++;
    if (m_idle == TIMEOUT) m_hang = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0);
    model_clear();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (commit_cnt !== 64'd0) begin errors++; $display("FAIL reset_commit_cnt got %0d exp 0", commit_cnt); end
    checks++; if ({order_err, overflow, hang} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b exp 000", {order_err, overflow, hang}); end
  endtask

  task automatic test_single_stream();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(i), 0, 0);
      tick();
      checks++; if (out_valid !== 1'b1 || out_index !== 8'(i)) begin errors++;
        $display("FAIL stream_out step %0d got valid %b index %0d exp valid 1 index %0d", i, out_valid, out_index, i); end
    end
    drive(0, 0, 0, 0);
    tick();
    checks++; if (commit_cnt !== 64'd10) begin errors++; $display("FAIL stream_cnt got %0d exp 10", commit_cnt); end
    checks++; if ({order_err, overflow, hang, out_valid} !== 4'b0000) begin errors++;
      $display("FAIL stream_flags got %b exp 0000", {order_err, overflow, hang, out_valid}); end
  endtask

  task automatic test_dual_fill();
    apply_reset();
    for (int i = 0; i < 3; i++) begin drive(1, 8'(2*i), 1, 8'(2*i+1)); tick(); end
    checks++; if (in_ready !== 1'b1 || commit_cnt !== 64'd6) begin errors++;
      $display("FAIL fill6 got in_ready %b cnt %0d exp 1 6", in_ready, commit_cnt); end
    drive(1, 8'd6, 1, 8'd7); tick();
    checks++; if (in_ready !== 1'b0 || commit_cnt !== 64'd8) begin errors++;
      $display("FAIL fill8 got in_ready %b cnt %0d exp 0 8", in_ready, commit_cnt); end
    drive(1, 8'd8, 0, 0); tick();
    checks++; if (overflow !== 1'b1 || commit_cnt !== 64'd8 || order_err !== 1'b0) begin errors++;
      $display("FAIL fill_overflow got ovf %b cnt %0d oerr %b exp 1 8 0", overflow, commit_cnt, order_err); end
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1 || out_index !== 8'(k)) begin errors++;
        $display("FAIL fill_drain %0d got valid %b index %0d exp 1 %0d", k, out_valid, out_index, k); end
      if (k == 1) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_seven_ready got %b exp 0", in_ready); end
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_wrap();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin drive(1, 8'(i), 0, 0); tick(); end
    drive(0, 0, 0, 0); tick();
    out_ready = 1'b0;
    drive(1, 8'h10, 1, 8'h11); tick();
    drive(0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_index !== 8'h10) begin errors++;
      $display("FAIL wrap_first got valid %b index %h exp 1 10", out_valid, out_index); end
    out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b1 || out_index !== 8'h11) begin errors++;
      $display("FAIL wrap_second got valid %b index %h exp 1 11", out_valid, out_index); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_index_err();
    apply_reset();
    out_ready = 1'b1;
    drive(1, 8'd0, 0, 0); tick();
    drive(1, 8'd1, 0, 0); tick();
    checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL idx_ok got %b exp 0", order_err); end
    drive(1, 8'd3, 0, 0); tick();
    checks++; if (order_err !== 1'b1 || err_expect !== 8'd2) begin errors++;
      $display("FAIL idx_err got oerr %b expect %0d exp 1 2", order_err, err_expect); end
    drive(1, 8'd9, 0, 0); tick();
    checks++; if (err_expect !== 8'd2) begin errors++; $display("FAIL idx_sticky got %0d exp 2", err_expect); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_illegal_port();
    apply_reset();
    drive(0, 0, 1, 8'd0); tick();
    drive(0, 0, 0, 0);
    checks++; if (order_err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b exp 1", order_err); end
    checks++; if (out_valid !== 1'b1 || out_index !== 8'd0 || commit_cnt !== 64'd1) begin errors++;
      $display("FAIL illegal_queued got valid %b index %0d cnt %0d exp 1 0 1", out_valid, out_index, commit_cnt); end
  endtask

  task automatic test_random();
    commit_rec_t got;
    int          r;
    logic [7:0]  i0, i1;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      r  = $urandom_range(0, 9);
      i0 = ($urandom_range(0, 19) == 0) ? 8'($urandom) : m_expect;
      i1 = ($urandom_range(0, 19) == 0) ? 8'($urandom) : m_expect + 8'd1;
      if (r == 9) i1 = m_expect;
      drive(r >= 3 && r <= 8, i0, r >= 6, i1);
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
      checks++; if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() <= DEPTH - 2)) begin errors++;
        $display("FAIL rnd_flow cycle %0d got valid %b ready %b model size %0d", c, out_valid, in_ready, mq.size()); end
      checks++; if (commit_cnt !== 64'(m_cnt)) begin errors++;
        $display("FAIL rnd_cnt cycle %0d got %0d exp %0d", c, commit_cnt, m_cnt); end
      checks++; if ({order_err, overflow, hang} !== {m_order_err, m_overflow, m_hang}) begin errors++;
        $display("FAIL rnd_flags cycle %0d got %b exp %b", c, {order_err, overflow, hang}, {m_order_err, m_overflow, m_hang}); end
      if (m_order_err) begin
        checks++; if (err_expect !== m_err_expect) begin errors++;
          $display("FAIL rnd_err_expect cycle %0d got %0d exp %0d", c, err_expect, m_err_expect); end
      end
      if (mq.size() != 0) begin
        got = '{idx: out_index, pc: out_pc, instr: out_instr, skip: out_skip,
                wen: out_wen, wdest: out_wdest, wdata: out_wdata};
        checks++; if (got !== mq[0]) begin errors++;
          $display("FAIL rnd_rec cycle %0d got %h exp %h", c, got, mq[0]); end
      end
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_hang_reset();
    apply_reset();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checks++; if (hang !== 1'b0) begin errors++; $display("FAIL hang_early got %b exp 0", hang); end
    tick();
    checks++; if (hang !== 1'b1) begin errors++; $display("FAIL hang_set got %b exp 1", hang); end
    drive(1, 8'd5, 0, 0); tick();
    drive(1, 8'd1, 1, 8'd2); tick();
    drive(1, 8'd3, 1, 8'd4); tick();
    drive(0, 0, 0, 0);
    checks++; if (hang !== 1'b1 || order_err !== 1'b1 || commit_cnt !== 64'd5) begin errors++;
      $display("FAIL hang_sticky got hang %b oerr %b cnt %0d exp 1 1 5", hang, order_err, commit_cnt); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL async_reset_queue got valid %b ready %b exp 0 1", out_valid, in_ready); end
    checks++; if ({order_err, overflow, hang} !== 3'b000 || commit_cnt !== 64'd0) begin errors++;
      $display("FAIL async_reset_flags got %b cnt %0d exp 000 0", {order_err, overflow, hang}, commit_cnt); end
    model_clear();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0);
    test_reset();
    test_single_stream();
    test_dual_fill();
    test_wrap();
    test_index_err();
    test_illegal_port();
    test_random();
    test_hang_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
